tick_bcd_counter: RTL and testbench

- Downstream consumer of the selectable-rate frequency divider's one-cycle tick pulse.
- Counts ticks as a two-digit BCD value, up or down, with run/pause control and terminal-count handling.
- Drives two active-low 7-segment displays on the board.
- Forms the counting/display stage of the many-frequencies counter project.

---
 rtl/tick_bcd_counter_if.sv | 26 ++
 rtl/tick_bcd_counter.sv | 171 +++++++++++++++++
 tb/tb_tick_bcd_counter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tick_bcd_counter_if.sv
// Control inputs and display/status outputs of the tick-driven BCD counter.
interface tick_bcd_counter_if;
  logic       tick;
  logic       start_stop;
  logic       clear;
  logic       up_down;
  logic       wrap_enable;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [6:0] hex1;
  logic [6:0] hex0;
  logic       running;
  logic       terminal;

  // Driver side: the board/testbench that supplies controls and reads the display.
  modport master (
    output tick, start_stop, clear, up_down, wrap_enable,
    input  bcd_tens, bcd_ones, hex1, hex0, running, terminal
  );

  // Counter side.
  modport slave (
    input  tick, start_stop, clear, up_down, wrap_enable,
    output bcd_tens, bcd_ones, hex1, hex0, running, terminal
  );
endinterface

// File: rtl/tick_bcd_counter.sv
// Two-digit BCD up/down counter advanced by divider ticks, with a push-button
// run/pause FSM, terminal-count handling and registered 7-segment decodes.
module tick_bcd_counter #(
  parameter int unsigned MAX_COUNT = 99
) (
  input logic               clock,
  input logic               reset,
  tick_bcd_counter_if.slave bus
);

  localparam logic [3:0] MaxTens = 4'(MAX_COUNT / 10);
  localparam logic [3:0] MaxOnes = 4'(MAX_COUNT % 10);

  typedef enum logic [1:0] {StStopped, StRunning, StPaused} state_e;

  // Active-low segment pattern, bit0 = segment a; blank for non-BCD codes.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       sync3_q, sync3_d;
  state_e     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       terminal_q, terminal_d;
  logic       running_q, running_d;
  logic [6:0] hex1_q, hex1_d;
  logic [6:0] hex0_q, hex0_d;

  logic   press;
  logic   at_max;
  logic   at_zero;
  state_e state_tick;

  // Button synchroniser, edge-detect history and display decodes.
  always_comb begin
    sync1_d = bus.start_stop;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    hex1_d  = seg7(tens_q);
    hex0_d  = seg7(ones_q);
  end

  // Rising edge of the synchronised button; a held button yields one press.
  assign press   = sync2_q & ~sync3_q;
  assign at_max  = (tens_q == MaxTens) && (ones_q == MaxOnes);
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);

  // Count update and FSM: clear beats press beats tick; a tick is judged
  // against the pre-press state and the press then acts on the result.
  always_comb begin
    tens_d     = tens_q;
    ones_d     = ones_q;
    state_d    = state_q;
    state_tick = state_q;
    terminal_d = 1'b0;

    if (bus.clear) begin
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      state_d = StStopped;
    end else begin
      if (bus.tick && (state_q == StRunning)) begin
        if (bus.up_down) begin
          if (at_max) begin
            terminal_d = 1'b1;
            if (bus.wrap_enable) begin
              tens_d = 4'd0;
              ones_d = 4'd0;
            end else begin
              state_tick = StStopped;
            end
          end else if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = tens_q + 4'd1;
          end else begin
            ones_d = ones_q + 4'd1;
          end
        end else begin
          if (at_zero) begin
            terminal_d = 1'b1;
            if (bus.wrap_enable) begin
              tens_d = MaxTens;
              ones_d = MaxOnes;
            end else begin
              state_tick = StStopped;
            end
          end else if (ones_q == 4'd0) begin
            ones_d = 4'd9;
            tens_d = tens_q - 4'd1;
          end else begin
            ones_d = ones_q - 4'd1;
          end
        end
      end

      state_d = state_tick;
      if (press) begin
        unique case (state_tick)
          StStopped: begin
            state_d = StRunning;
            // Starting from the limit of the chosen direction restarts the sweep.
            if (bus.up_down && (tens_d == MaxTens) && (ones_d == MaxOnes)) begin
              tens_d = 4'd0;
              ones_d = 4'd0;
            end else if (!bus.up_down && (tens_d == 4'd0) && (ones_d == 4'd0)) begin
              tens_d = MaxTens;
              ones_d = MaxOnes;
            end
          end
          StRunning: state_d = StPaused;
          StPaused:  state_d = StRunning;
          default:   state_d = StStopped;
        endcase
      end
    end

    running_d = (state_d == StRunning);
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      state_q    <= StStopped;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      terminal_q <= 1'b0;
      running_q  <= 1'b0;
      hex1_q     <= 7'b1000000;
      hex0_q     <= 7'b1000000;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      state_q    <= state_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      terminal_q <= terminal_d;
      running_q  <= running_d;
      hex1_q     <= hex1_d;
      hex0_q     <= hex0_d;
    end
  end

  assign bus.bcd_tens = tens_q;
  assign bus.bcd_ones = ones_q;
  assign bus.hex1     = hex1_q;
  assign bus.hex0     = hex0_q;
  assign bus.running  = running_q;
  assign bus.terminal = terminal_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Self-checking bench for tick_bcd_counter (MAX_COUNT = 99).
module tb_tick_bcd_counter;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  tick_bcd_counter_if bus_if ();

  tick_bcd_counter #(
    .MAX_COUNT(99)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  typedef struct {
    logic       up;
    logic       wrap;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       term;
    logic       run;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       term;
    logic       run;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  logic [6:0] seg[10];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input string name, input logic [3:0] tens, input logic [3:0] ones,
                          input logic term, input logic run);
    exp_t e;
    e.name = name;
    e.tens = tens;
    e.ones = ones;
    e.term = term;
    e.run  = run;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.name, ".tens"}, 8'(bus_if.bcd_tens), 8'(e.tens));
      chk({e.name, ".ones"}, 8'(bus_if.bcd_ones), 8'(e.ones));
      chk({e.name, ".terminal"}, 8'(bus_if.terminal), 8'(e.term));
      chk({e.name, ".running"}, 8'(bus_if.running), 8'(e.run));
    end
  endtask

  // One tick from the table, then a gap cycle that checks the display caught up.
  task automatic apply_vec(input int idx);
    vec_t  v;
    string nm;
    v  = vecs[idx];
    nm = $sformatf("vec%0d", idx);
    bus_if.up_down     = v.up;
    bus_if.wrap_enable = v.wrap;
    bus_if.tick        = 1'b1;
    push_exp(nm, v.tens, v.ones, v.term, v.run);
    step();
    bus_if.tick = 1'b0;
    pop_check();
    step();
    chk({nm, ".hex1"}, 8'(bus_if.hex1), 8'(seg[v.tens]));
    chk({nm, ".hex0"}, 8'(bus_if.hex0), 8'(seg[v.ones]));
    chk({nm, ".terminal_gap"}, 8'(bus_if.terminal), 8'd0);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.tick = 1'b1;
      step();
      bus_if.tick = 1'b0;
      step();
    end
  endtask

  // Button down for two clocks: the press takes effect at the next edge.
  task automatic press_begin();
    bus_if.start_stop = 1'b1;
    step();
    step();
  endtask

  task automatic press_release();
    bus_if.start_stop = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic add_vec(input logic up, input logic wrap, input logic [3:0] tens,
                         input logic [3:0] ones, input logic term, input logic run);
    vec_t v;
    v.up   = up;
    v.wrap = wrap;
    v.tens = tens;
    v.ones = ones;
    v.term = term;
    v.run  = run;
    vecs.push_back(v);
  endtask

  initial begin
    seg[0] = 7'b1000000;
    seg[1] = 7'b1111001;
    seg[2] = 7'b0100100;
    seg[3] = 7'b0110000;
    seg[4] = 7'b0011001;
    seg[5] = 7'b0010010;
    seg[6] = 7'b0000010;
    seg[7] = 7'b1111000;
    seg[8] = 7'b0000000;
    seg[9] = 7'b0010000;

    // 0..11: count up 01..12 with wrap on
    for (int i = 1; i <= 12; i++) add_vec(1'b1, 1'b1, 4'(i / 10), 4'(i % 10), 1'b0, 1'b1);
    // 12..13: 98 -> 99 -> 00 with wrap, terminal on the second
    add_vec(1'b1, 1'b1, 4'd9, 4'd9, 1'b0, 1'b1);
    add_vec(1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1);
    // 14: up to 01
    add_vec(1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b1);
    // 15..17: down, hold: 01 -> 00, stop at 00 with terminal, then ignored
    add_vec(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    add_vec(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    add_vec(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    reset              = 1'b1;
    bus_if.tick        = 1'b0;
    bus_if.start_stop  = 1'b0;
    bus_if.clear       = 1'b0;
    bus_if.up_down     = 1'b1;
    bus_if.wrap_enable = 1'b1;
    #2;
    chk("reset.tens", 8'(bus_if.bcd_tens), 8'd0);
    chk("reset.ones", 8'(bus_if.bcd_ones), 8'd0);
    chk("reset.hex1", 8'(bus_if.hex1), 8'(7'b1000000));
    chk("reset.hex0", 8'(bus_if.hex0), 8'(7'b1000000));
    chk("reset.running", 8'(bus_if.running), 8'd0);
    chk("reset.terminal", 8'(bus_if.terminal), 8'd0);
    step();
    reset = 1'b0;
    step();

    // Ticks while stopped are ignored
    run_ticks(3);
    chk("idle.ones", 8'(bus_if.bcd_ones), 8'd0);
    chk("idle.hex0", 8'(bus_if.hex0), 8'(7'b1000000));
    chk("idle.running", 8'(bus_if.running), 8'd0);

    // First press: running rises on the third clock after the button
    press_begin();
    chk("press.latency_early", 8'(bus_if.running), 8'd0);
    step();
    chk("press.running", 8'(bus_if.running), 8'd1);
    for (int i = 0; i < 4; i++) step();
    chk("press.held_once", 8'(bus_if.running), 8'd1);
    press_release();

    for (int i = 0; i <= 11; i++) apply_vec(i);
    chk("twelve.hex1", 8'(bus_if.hex1), 8'(7'b1111001));
    chk("twelve.hex0", 8'(bus_if.hex0), 8'(7'b0100100));

    run_ticks(86);
    chk("at98.tens", 8'(bus_if.bcd_tens), 8'd9);
    chk("at98.ones", 8'(bus_if.bcd_ones), 8'd8);
    for (int i = 12; i <= 17; i++) apply_vec(i);

    // Restart from 00 counting down reloads MAX_COUNT
    press_begin();
    step();
    chk("reload.tens", 8'(bus_if.bcd_tens), 8'd9);
    chk("reload.ones", 8'(bus_if.bcd_ones), 8'd9);
    chk("reload.running", 8'(bus_if.running), 8'd1);
    press_release();

    // Clear, restart up, reach 05
    bus_if.clear = 1'b1;
    step();
    bus_if.clear = 1'b0;
    chk("clear.ones", 8'(bus_if.bcd_ones), 8'd0);
    chk("clear.running", 8'(bus_if.running), 8'd0);
    bus_if.up_down     = 1'b1;
    bus_if.wrap_enable = 1'b1;
    press_begin();
    step();
    press_release();
    run_ticks(5);
    chk("at05.ones", 8'(bus_if.bcd_ones), 8'd5);

    // Press coincident with tick: count once, then pause
    bus_if.start_stop = 1'b1;
    step();
    step();
    bus_if.tick = 1'b1;
    push_exp("press_tick", 4'd0, 4'd6, 1'b0, 1'b0);
    step();
    bus_if.tick = 1'b0;
    pop_check();
    run_ticks(2);
    chk("paused.ones", 8'(bus_if.bcd_ones), 8'd6);
    chk("paused.running", 8'(bus_if.running), 8'd0);
    press_release();
    press_begin();
    step();
    chk("resume.running", 8'(bus_if.running), 8'd1);
    press_release();
    bus_if.tick = 1'b1;
    push_exp("resume_tick", 4'd0, 4'd7, 1'b0, 1'b1);
    step();
    bus_if.tick = 1'b0;
    pop_check();
    step();

    // Clear with a coincident tick at 40
    run_ticks(33);
    chk("at40.tens", 8'(bus_if.bcd_tens), 8'd4);
    chk("at40.ones", 8'(bus_if.bcd_ones), 8'd0);
    bus_if.clear = 1'b1;
    bus_if.tick  = 1'b1;
    push_exp("clear_tick", 4'd0, 4'd0, 1'b0, 1'b0);
    step();
    bus_if.clear = 1'b0;
    bus_if.tick  = 1'b0;
    pop_check();
    step();
    chk("clear_tick.terminal_gap", 8'(bus_if.terminal), 8'd0);

    // Async reset mid-run at 37, observed between clock edges
    press_begin();
    step();
    press_release();
    run_ticks(37);
    chk("at37.tens", 8'(bus_if.bcd_tens), 8'd3);
    chk("at37.ones", 8'(bus_if.bcd_ones), 8'd7);
    chk("at37.hex1", 8'(bus_if.hex1), 8'(7'b0110000));
    chk("at37.hex0", 8'(bus_if.hex0), 8'(7'b1111000));
    #1;
    reset = 1'b1;
    #1;
    chk("async.tens", 8'(bus_if.bcd_tens), 8'd0);
    chk("async.ones", 8'(bus_if.bcd_ones), 8'd0);
    chk("async.hex1", 8'(bus_if.hex1), 8'(7'b1000000));
    chk("async.hex0", 8'(bus_if.hex0), 8'(7'b1000000));
    chk("async.running", 8'(bus_if.running), 8'd0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
